rgmii_tx_encoder: RTL and testbench
===================================

# rgmii_tx_encoder

Transmit-side RGMII encoder sitting directly upstream of the source-synchronous DDR output stage. It accepts GMII-style bytes from the MAC and produces per-cycle rising/falling-edge data words for a 5-bit DDR output: bits [3:0] are TXD and bit 4 is TX_CTL. It also produces edge patterns for the forwarded-clock DDR register. At 1000 Mb/s it splits each byte across the two clock edges. At 10/100 Mb/s it serialises nibbles and synthesises the slow TX clock from the 125 MHz `clk`.

## Interface
Parameters:
- `CLK_DIV_100`, default 5: `clk` cycles per nibble at 100 Mb/s (N100). Must be ≥2.
- `CLK_DIV_10`, default 50: `clk` cycles per nibble at 10 Mb/s (N10). Must be ≥2.

Ports:
- `clk`, input, 1: 125 MHz transmit clock. This is the only clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `speed`, input, 2: speed select. 2'b00 selects 10, 2'b01 selects 100, 2'b10 and 2'b11 select 1000.
- `gmii_txd`, input, 8: byte from the MAC.
- `gmii_tx_en`, input, 1: frame enable.
- `gmii_tx_er`, input, 1: transmit error.
- `gmii_clk_en`, output, 1: byte-accept strobe. The MAC byte is captured at the rising edge that ends a cycle in which this is 1.
- `rgmii_d1`, output, 5: rising-edge word, {ctl, txd[3:0]}.
- `rgmii_d2`, output, 5: falling-edge word, {ctl, txd[3:0]}.
- `rgmii_clk_d1`, output, 1: forwarded-clock rising-edge level.
- `rgmii_clk_d2`, output, 1: forwarded-clock falling-edge level.

## Operation
- **Mode and nibble length:**
  - Mode 1000 when `speed_reg` is 2'b1x. The byte period P is 1 cycle.
  - Mode 100/10 uses a nibble length N = N100 or N10, and P = 2N.
- **State:** `speed_reg` (reset 2'b10) and phase counter `p` (reset 0, range 0..P-1).
- **`gmii_clk_en`:**
  - Equals 1 when `p == P-1`.
  - Forced 0 in any cycle where `speed != speed_reg`.
  - In mode 1000 it is therefore constantly 1 after reset while speed is stable.
- **Capture:** at an accepting edge, a byte register latches `gmii_txd`. `ctl1` latches `gmii_tx_en`. `ctl2` latches `gmii_tx_en ^ gmii_tx_er`.
- **Mode 1000 outputs** (registered from the captured values):
  - `rgmii_d1` = {ctl1, txd[3:0]}.
  - `rgmii_d2` = {ctl2, txd[7:4]}.
  - `rgmii_clk_d1` = 1, `rgmii_clk_d2` = 0.
- **Mode 100/10 outputs**, with n = p mod N:
  - While p < N: `rgmii_d1` = `rgmii_d2` = {ctl, txd[3:0]}.
  - While p ≥ N: `rgmii_d1` = `rgmii_d2` = {ctl, txd[7:4]}.
  - In those words ctl is ctl1 on `rgmii_d1` and ctl2 on `rgmii_d2`.
  - `rgmii_clk_d1` = (2n ≥ N); `rgmii_clk_d2` = (2n+1 ≥ N).
  - The forwarded clock is low for the first N half-cycles of each nibble and high for the last N. Its rising edge is centred in the nibble.
- **Counter:** `p` increments each cycle and wraps from P-1 to 0 on the accepting edge. The low nibble of a new byte is therefore driven starting the cycle after capture.
- **Speed change** (edge at which `speed != speed_reg`):
  - `speed_reg` ← `speed` and `p` ← P_new-1.
  - All outputs are driven 0 for the following cycle (idle, clock low).
  - `gmii_clk_en` = 1 in that following cycle.
  - Any partially sent byte is abandoned. The MAC must hold `gmii_tx_en` low across speed changes; the block does not check this.
- **Reset:** asynchronous. `rgmii_d1`, `rgmii_d2`, `rgmii_clk_d1` and `rgmii_clk_d2` are all 0, and the byte/ctl registers are 0. `gmii_clk_en` reads 1 if `speed` is 1000, else 0.

## Timing
- Latency is 1 cycle from the accepting edge to the byte's first output word.
- Mode 1000 throughput is 1 byte/cycle. Mode 100/10 throughput is 1 byte per 2N cycles; with defaults that is 10 and 100 cycles.
- All outputs except `gmii_clk_en` are registers. `gmii_clk_en` is decoded from `p` and `speed_reg`, with a single compare against `speed`.
- Counter width is ⌈log2(2·max(N100, N10))⌉ bits.

## Configuration
- Macro: `RGMII_TX_ENCODER_TX_ER_EN`.
- Defined: ctl2 = `gmii_tx_en ^ gmii_tx_er`, giving standard RGMII error signalling.
- Undefined: `gmii_tx_er` is ignored and ctl2 = `gmii_tx_en`, so the falling-edge ctl is always equal to the rising-edge ctl.

## Test plan
- **Mode 1000, macro defined:** drive `speed`=2'b10 and bytes 0x55, 0xD5, 0xA3 with tx_en=1, tx_er=0. Expect `gmii_clk_en` constantly 1. One cycle later `rgmii_d1`/`rgmii_d2` read 5'h15/5'h15, then 5'h15/5'h1D, then 5'h13/5'h1A. Clock bits read 1/0.
- **Mode 100, defaults:** send byte 0xA3 with tx_en=1. Expect `gmii_clk_en` to pulse every 10 cycles. Both words read 5'h13 for 5 cycles, then 5'h1A for 5 cycles. Per nibble, `rgmii_clk_d1`/`rgmii_clk_d2` read 0/0, 0/0, 0/1, 1/1, 1/1.
- **Mode 10:** `gmii_clk_en` pulses exactly every 100 cycles. The clock pair reads 0/0 for n=0..24 and 1/1 for n=25..49.
- **tx_er, mode 1000:** tx_en=1, tx_er=1, byte 0x00. With the macro defined, expect ctl d1=1, d2=0. With the macro undefined, expect ctl d1=1, d2=1.
- **Speed change mid-byte:** switch 100→1000 at p=3. Expect `gmii_clk_en`=0 in the change cycle, then one all-zero output cycle with `gmii_clk_en`=1, then 1000 operation.
- **Reset mid-nibble:** assert `rst` asynchronously at p=7 in mode 100. Outputs go to 0 immediately, without waiting for a clock edge. After release with `speed`=2'b01, the restart sequence occurs and the first byte is captured 2 edges later.

Source files
------------

// File: rtl/rgmii_tx_encoder.sv
// rtl/rgmii_tx_encoder.sv - GMII byte to RGMII DDR word encoder with 10/100 nibble serialiser
// Optional macro RGMII_TX_ENCODER_TX_ER_EN: drive tx_en ^ tx_er on the falling-edge ctl.
module rgmii_tx_encoder #(
    parameter int CLK_DIV_100 = 5,
    parameter int CLK_DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_clk_en,
    output logic [4:0] rgmii_d1,
    output logic [4:0] rgmii_d2,
    output logic       rgmii_clk_d1,
    output logic       rgmii_clk_d2
);

    localparam int MAX_N = (CLK_DIV_100 > CLK_DIV_10) ? CLK_DIV_100 : CLK_DIV_10;
    localparam int CW    = $clog2(2 * MAX_N);

    function automatic logic [CW-1:0] nib_len_f(input logic [1:0] s);
        return s[0] ? CW'(CLK_DIV_100) : CW'(CLK_DIV_10);
    endfunction

    function automatic logic [CW-1:0] last_phase_f(input logic [1:0] s);
        return s[1] ? '0 : CW'((nib_len_f(s) << 1) - CW'(1));
    endfunction

    logic [1:0]    speed_reg;
    logic [CW-1:0] p;
    logic [7:0]    byte_reg;
    logic          ctl1;
    logic          ctl2;

    logic          speed_change;
    logic          accept;
    logic [CW-1:0] nib_len;
    logic [CW-1:0] p_n;
    logic [CW-1:0] n_n;
    logic [7:0]    byte_n;
    logic          ctl1_n;
    logic          ctl2_n;
    logic [3:0]    nib_n;
    logic          clk1_n;
    logic          clk2_n;

`ifndef RGMII_TX_ENCODER_TX_ER_EN
    logic unused_tx_er;
    assign unused_tx_er = gmii_tx_er;
`endif

    assign speed_change = (speed != speed_reg);
    assign accept       = (p == last_phase_f(speed_reg)) && !speed_change;
    assign gmii_clk_en  = accept;

    // Outputs for the next cycle are derived from the post-edge phase and captured byte,
    // so a byte accepted at an edge appears on the wire in the very next cycle.
    always_comb begin
        nib_len = nib_len_f(speed_reg);
        byte_n  = byte_reg;
        ctl1_n  = ctl1;
        ctl2_n  = ctl2;
        p_n     = p + CW'(1);
        if (accept) begin
            byte_n = gmii_txd;
            ctl1_n = gmii_tx_en;
`ifdef RGMII_TX_ENCODER_TX_ER_EN
            ctl2_n = gmii_tx_en ^ gmii_tx_er;
`else
            ctl2_n = gmii_tx_en;
`endif
            p_n    = '0;
        end
        n_n    = (p_n >= nib_len) ? p_n - nib_len : p_n;
        nib_n  = (p_n < nib_len) ? byte_n[3:0] : byte_n[7:4];
        clk1_n = ({n_n, 1'b0} >= {1'b0, nib_len});
        clk2_n = ({n_n, 1'b1} >= {1'b0, nib_len});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_reg    <= 2'b10;
            p            <= '0;
            byte_reg     <= '0;
            ctl1         <= 1'b0;
            ctl2         <= 1'b0;
            rgmii_d1     <= '0;
            rgmii_d2     <= '0;
            rgmii_clk_d1 <= 1'b0;
            rgmii_clk_d2 <= 1'b0;
        end else if (speed_change) begin
            // Abandon the byte in flight; idle one cycle, then accept at the new rate.
            speed_reg    <= speed;
            p            <= last_phase_f(speed);
            rgmii_d1     <= '0;
            rgmii_d2     <= '0;
            rgmii_clk_d1 <= 1'b0;
            rgmii_clk_d2 <= 1'b0;
        end else begin
            p        <= p_n;
            byte_reg <= byte_n;
            ctl1     <= ctl1_n;
            ctl2     <= ctl2_n;
            if (speed_reg[1]) begin
                rgmii_d1     <= {ctl1_n, byte_n[3:0]};
                rgmii_d2     <= {ctl2_n, byte_n[7:4]};
                rgmii_clk_d1 <= 1'b1;
                rgmii_clk_d2 <= 1'b0;
            end else begin
                rgmii_d1     <= {ctl1_n, nib_n};
                rgmii_d2     <= {ctl2_n, nib_n};
                rgmii_clk_d1 <= clk1_n;
                rgmii_clk_d2 <= clk2_n;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_tx_encoder.sv
// tb/tb_rgmii_tx_encoder.sv - randomized bench for rgmii_tx_encoder against a behavioural model
module tb_rgmii_tx_encoder;

    localparam int N100 = 5;
    localparam int N10  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       gmii_clk_en;
    logic [4:0] rgmii_d1;
    logic [4:0] rgmii_d2;
    logic       rgmii_clk_d1;
    logic       rgmii_clk_d2;

    int n_checks = 0;
    int n_pass   = 0;

    rgmii_tx_encoder #(.CLK_DIV_100(N100), .CLK_DIV_10(N10)) dut (
        .clk          (clk),
        .rst          (rst),
        .speed        (speed),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .gmii_clk_en  (gmii_clk_en),
        .rgmii_d1     (rgmii_d1),
        .rgmii_d2     (rgmii_d2),
        .rgmii_clk_d1 (rgmii_clk_d1),
        .rgmii_clk_d2 (rgmii_clk_d2)
    );

    always #5 clk = ~clk;

    // Model state: the rate in force, the position within the byte period, the last byte taken
    // from the MAC and whether the line is in its post-reset / post-rate-change idle cycle.
    int       m_speed;
    int       m_p;
    int       m_byte;
    int       m_ctl1;
    int       m_ctl2;
    bit       m_idle;

    function automatic int period(input int s);
        if (s >= 2) return 1;
        return 2 * ((s == 1) ? N100 : N10);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_speed = 2; m_p = 0; m_byte = 0; m_ctl1 = 0; m_ctl2 = 0; m_idle = 1;
    endtask

    task automatic check_outputs(input string tag);
        int nl, n, nib, e1, e2, c1, c2;
        if (m_idle) begin
            e1 = 0; e2 = 0; c1 = 0; c2 = 0;
        end else if (m_speed >= 2) begin
            e1 = m_ctl1 * 16 + m_byte % 16;
            e2 = m_ctl2 * 16 + m_byte / 16;
            c1 = 1; c2 = 0;
        end else begin
            nl  = (m_speed == 1) ? N100 : N10;
            n   = m_p % nl;
            nib = (m_p < nl) ? m_byte % 16 : m_byte / 16;
            e1  = m_ctl1 * 16 + nib;
            e2  = m_ctl2 * 16 + nib;
            c1  = (2 * n >= nl) ? 1 : 0;
            c2  = (2 * n + 1 >= nl) ? 1 : 0;
        end
        check({tag, ".d1"}, int'(rgmii_d1), e1);
        check({tag, ".d2"}, int'(rgmii_d2), e2);
        check({tag, ".clk"}, int'({rgmii_clk_d1, rgmii_clk_d2}), c1 * 2 + c2);
    endtask

    // Drive one cycle's inputs at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input string tag, input logic [1:0] sp, input logic [7:0] d,
                         input logic en, input logic er);
        int exp_en;
        speed = sp; gmii_txd = d; gmii_tx_en = en; gmii_tx_er = er;
        #1;
        exp_en = (int'(sp) == m_speed && m_p == period(m_speed) - 1) ? 1 : 0;
        check({tag, ".clk_en"}, int'(gmii_clk_en), exp_en);
        check_outputs(tag);
        @(posedge clk);
        if (int'(sp) != m_speed) begin
            m_speed = int'(sp);
            m_p     = period(m_speed) - 1;
            m_idle  = 1;
        end else begin
            if (m_p == period(m_speed) - 1) begin
                m_byte = int'(d);
                m_ctl1 = int'(en);
`ifdef RGMII_TX_ENCODER_TX_ER_EN
                m_ctl2 = int'(en ^ er);
`else
                m_ctl2 = int'(en);
`endif
                m_p = 0;
            end else begin
                m_p = m_p + 1;
            end
            m_idle = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pre [3];
        logic [1:0] sp;
        int         len;
        int         waited;

        pre[0] = 8'h55; pre[1] = 8'hD5; pre[2] = 8'hA3;
        rst = 1'b1; speed = 2'b10; gmii_txd = '0; gmii_tx_en = 1'b0; gmii_tx_er = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset.clk_en", int'(gmii_clk_en), 1);
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Gigabit preamble/SFD and a data byte.
        for (int i = 0; i < 3; i++) cycle("g1000", 2'b10, pre[i], 1'b1, 1'b0);
        cycle("g1000", 2'b10, 8'h00, 1'b1, 1'b1);
        // The error byte is on the wire this cycle.
        check("tx_er.d1_ctl", int'(rgmii_d1[4]), 1);
`ifdef RGMII_TX_ENCODER_TX_ER_EN
        check("tx_er.d2_ctl", int'(rgmii_d2[4]), 0);
`else
        check("tx_er.d2_ctl", int'(rgmii_d2[4]), 1);
`endif

        // 100 Mb/s: change, then repeated 0xA3 frames.
        for (int i = 0; i < 25; i++) cycle("m100", 2'b01, 8'hA3, 1'b1, 1'b0);
        // 10 Mb/s: two full bytes of clock pattern.
        for (int i = 0; i < 220; i++) cycle("m10", 2'b00, 8'h3C, 1'b1, 1'b0);

        // Randomized segments with mid-byte rate changes.
        for (int s = 0; s < 10; s++) begin
            sp  = 2'($urandom_range(0, 3));
            len = $urandom_range(15, 160);
            for (int i = 0; i < len; i++)
                cycle("rand", sp, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of a 100 Mb/s nibble.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 2'b01, 8'hA3, 1'b1, 1'b0);
        waited = 0;
        while (m_p != 7 && waited < 40) begin
            cycle("pre_rst", 2'b01, 8'hA3, 1'b1, 1'b0);
            waited++;
        end
        check("rst.reached_p7", m_p, 7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst.async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) cycle("post_rst", 2'b01, 8'($urandom), 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
